cond_unit: RTL and testbench

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_unit_pkg.sv | 29 ++
 rtl/cond_unit_check.sv | 45 ++++
 rtl/cond_unit.sv | 85 ++++++++
 tb/tb_cond_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cond_unit_pkg.sv
// Shared definitions for the Execute-stage condition unit: ARM condition
// codes and the bit positions of N, Z, C and V inside the flag register.
package cond_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ  = 4'b0000,
        COND_NE  = 4'b0001,
        COND_CS  = 4'b0010,
        COND_CC  = 4'b0011,
        COND_MI  = 4'b0100,
        COND_PL  = 4'b0101,
        COND_VS  = 4'b0110,
        COND_VC  = 4'b0111,
        COND_HI  = 4'b1000,
        COND_LS  = 4'b1001,
        COND_GE  = 4'b1010,
        COND_LT  = 4'b1011,
        COND_GT  = 4'b1100,
        COND_LE  = 4'b1101,
        COND_AL  = 4'b1110,
        COND_UNC = 4'b1111
    } cond_code_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_check.sv
// Pure combinational ARM condition evaluation of a 4-bit condition field
// against an NZCV flag word.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    // The unconditional 1111 encoding is treated the same as AL.
    always_comb begin
        o_pass = 1'b0;
        case (cond_code_e'(i_cond))
            COND_EQ:  o_pass = w_z;
            COND_NE:  o_pass = ~w_z;
            COND_CS:  o_pass = w_c;
            COND_CC:  o_pass = ~w_c;
            COND_MI:  o_pass = w_n;
            COND_PL:  o_pass = ~w_n;
            COND_VS:  o_pass = w_v;
            COND_VC:  o_pass = ~w_v;
            COND_HI:  o_pass = w_c & ~w_z;
            COND_LS:  o_pass = ~w_c | w_z;
            COND_GE:  o_pass = (w_n == w_v);
            COND_LT:  o_pass = (w_n != w_v);
            COND_GT:  o_pass = ~w_z & (w_n == w_v);
            COND_LE:  o_pass = w_z | (w_n != w_v);
            COND_AL:  o_pass = 1'b1;
            COND_UNC: o_pass = 1'b1;
            default:  o_pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: gates the decoded controls of the Execute
// instruction by its condition and owns the architectural NZCV register.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       flush,
    input  logic       valid_e,
    input  logic [3:0] cond_e,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_write_e,
    input  logic       reg_write_e,
    input  logic       mem_write_e,
    input  logic       pc_src_e,
    input  logic       branch_e,
    input  logic       no_write_e,
    output logic       cond_ex_e,
    output logic       branch_taken_e,
    output logic [3:0] flags,
    output logic       reg_write_m,
    output logic       mem_write_m,
    output logic       pc_src_m
);

    logic [3:0] r_flags;
    logic       r_regWriteM;
    logic       r_memWriteM;
    logic       r_pcSrcM;

    logic       w_condPass;
    logic       w_condEx;
    logic       w_loadNz;
    logic       w_loadCv;

    // The condition always sees the registered flags, never alu_flags.
    cond_check u_cond_check (
        .i_cond  (cond_e),
        .i_flags (r_flags),
        .o_pass  (w_condPass)
    );

    assign w_condEx = w_condPass & valid_e & ~flush;
    assign w_loadNz = en & w_condEx & flag_write_e[1];
    assign w_loadCv = en & w_condEx & flag_write_e[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= FLAG_RESET;
        end else begin
            if (w_loadNz) begin
                r_flags[FLAG_N] <= alu_flags[FLAG_N];
                r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (w_loadCv) begin
                r_flags[FLAG_C] <= alu_flags[FLAG_C];
                r_flags[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

    // A flushed instruction has w_condEx low, so its M-stage controls load as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_regWriteM <= 1'b0;
            r_memWriteM <= 1'b0;
            r_pcSrcM    <= 1'b0;
        end else if (en) begin
            r_regWriteM <= reg_write_e & w_condEx & ~no_write_e;
            r_memWriteM <= mem_write_e & w_condEx;
            r_pcSrcM    <= pc_src_e & w_condEx;
        end
    end

    assign cond_ex_e      = w_condEx;
    assign branch_taken_e = branch_e & w_condEx;
    assign flags          = r_flags;
    assign reg_write_m    = r_regWriteM;
    assign mem_write_m    = r_memWriteM;
    assign pc_src_m       = r_pcSrcM;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: vector table with a queue of expected
// post-edge state, reset corner cases and an exhaustive condition sweep.
module tb_cond_unit;

    typedef struct packed {
        logic       en;
        logic       flush;
        logic       valid;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       rw;
        logic       mw;
        logic       pc;
        logic       br;
        logic       nw;
        logic       expCex;
        logic       expBr;
        logic [3:0] expFlags;
        logic       expRw;
        logic       expMw;
        logic       expPc;
    } vec_t;

    typedef struct packed {
        logic [3:0] flags;
        logic       rw;
        logic       mw;
        logic       pc;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       flush;
    logic       valid_e;
    logic [3:0] cond_e;
    logic [3:0] alu_flags;
    logic [1:0] flag_write_e;
    logic       reg_write_e;
    logic       mem_write_e;
    logic       pc_src_e;
    logic       branch_e;
    logic       no_write_e;
    logic       cond_ex_e;
    logic       branch_taken_e;
    logic [3:0] flags;
    logic       reg_write_m;
    logic       mem_write_m;
    logic       pc_src_m;

    int   total = 0;
    int   bad = 0;
    exp_t expQ[$];
    vec_t vecs[18];

    cond_unit #(.FLAG_RESET(4'b0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .en             (en),
        .flush          (flush),
        .valid_e        (valid_e),
        .cond_e         (cond_e),
        .alu_flags      (alu_flags),
        .flag_write_e   (flag_write_e),
        .reg_write_e    (reg_write_e),
        .mem_write_e    (mem_write_e),
        .pc_src_e       (pc_src_e),
        .branch_e       (branch_e),
        .no_write_e     (no_write_e),
        .cond_ex_e      (cond_ex_e),
        .branch_taken_e (branch_taken_e),
        .flags          (flags),
        .reg_write_m    (reg_write_m),
        .mem_write_m    (mem_write_m),
        .pc_src_m       (pc_src_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition: pairs of codes share a base test, odd code inverts it.
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = ~(n ^ v);
            3'd6: base = ~(n ^ v) & ~z;
            default: base = 1'b1;
        endcase
        return (c == 4'b1111) ? 1'b1 : (base ^ c[0]);
    endfunction

    function automatic vec_t mkVec(
        input logic e, input logic fl, input logic va, input logic [3:0] c,
        input logic [3:0] a, input logic [1:0] w, input logic rw, input logic mw,
        input logic pc, input logic br, input logic nw, input logic xc,
        input logic xb, input logic [3:0] xf, input logic xr, input logic xm,
        input logic xp);
        vec_t r;
        r = '{e, fl, va, c, a, w, rw, mw, pc, br, nw, xc, xb, xf, xr, xm, xp};
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one instruction at the falling edge, check the combinational outputs, and queue the post-edge state.
    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        en           = v.en;
        flush        = v.flush;
        valid_e      = v.valid;
        cond_e       = v.cond;
        alu_flags    = v.alu;
        flag_write_e = v.fw;
        reg_write_e  = v.rw;
        mem_write_e  = v.mw;
        pc_src_e     = v.pc;
        branch_e     = v.br;
        no_write_e   = v.nw;
        #1;
        checkVal({tag, " cond_ex_e"}, {3'b0, cond_ex_e}, {3'b0, v.expCex});
        checkVal({tag, " branch_taken_e"}, {3'b0, branch_taken_e}, {3'b0, v.expBr});
        e.flags = v.expFlags;
        e.rw    = v.expRw;
        e.mw    = v.expMw;
        e.pc    = v.expPc;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s scoreboard: queue empty", tag);
        end else begin
            e = expQ.pop_front();
            checkVal({tag, " flags"}, flags, e.flags);
            checkVal({tag, " reg_write_m"}, {3'b0, reg_write_m}, {3'b0, e.rw});
            checkVal({tag, " mem_write_m"}, {3'b0, mem_write_m}, {3'b0, e.mw});
            checkVal({tag, " pc_src_m"}, {3'b0, pc_src_m}, {3'b0, e.pc});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Fields: en flush valid cond alu fw rw mw pc br nw | cex br flags rwM mwM pcM
        vecs[0]  = mkVec(1,0,1,4'b0000,4'b0000,2'b00,0,0,0,0,0, 0,0,4'b0000,0,0,0);
        vecs[1]  = mkVec(1,0,1,4'b1110,4'b0100,2'b11,0,0,0,0,0, 1,0,4'b0100,0,0,0);
        vecs[2]  = mkVec(1,0,1,4'b0000,4'b0000,2'b00,1,0,0,0,0, 1,0,4'b0100,1,0,0);
        vecs[3]  = mkVec(1,0,1,4'b1110,4'b1000,2'b11,0,0,0,0,0, 1,0,4'b1000,0,0,0);
        vecs[4]  = mkVec(1,0,1,4'b1110,4'b0011,2'b01,0,0,0,0,0, 1,0,4'b1011,0,0,0);
        vecs[5]  = mkVec(1,0,1,4'b0100,4'b0000,2'b00,0,0,1,1,0, 1,1,4'b1011,0,0,1);
        vecs[6]  = mkVec(1,0,1,4'b0101,4'b0000,2'b11,0,0,1,1,0, 0,0,4'b1011,0,0,0);
        vecs[7]  = mkVec(1,0,1,4'b1110,4'b0000,2'b00,1,1,0,0,1, 1,0,4'b1011,0,1,0);
        vecs[8]  = mkVec(1,1,1,4'b1110,4'b0100,2'b11,0,1,0,0,0, 0,0,4'b1011,0,0,0);
        vecs[9]  = mkVec(1,0,1,4'b1110,4'b0000,2'b00,1,1,1,0,0, 1,0,4'b1011,1,1,1);
        vecs[10] = mkVec(0,0,1,4'b1110,4'b0100,2'b11,0,0,0,0,0, 1,0,4'b1011,1,1,1);
        vecs[11] = mkVec(0,0,1,4'b1110,4'b0100,2'b11,0,0,0,0,0, 1,0,4'b1011,1,1,1);
        vecs[12] = mkVec(0,0,1,4'b1110,4'b0100,2'b11,0,0,0,0,0, 1,0,4'b1011,1,1,1);
        vecs[13] = mkVec(1,0,1,4'b1110,4'b0100,2'b11,0,0,0,0,0, 1,0,4'b0100,0,0,0);
        vecs[14] = mkVec(1,0,1,4'b1110,4'b0000,2'b00,1,1,0,0,0, 1,0,4'b0100,1,1,0);
        vecs[15] = mkVec(0,1,1,4'b1110,4'b0000,2'b11,0,0,0,0,0, 0,0,4'b0100,1,1,0);
        vecs[16] = mkVec(1,1,1,4'b1110,4'b0000,2'b11,0,0,0,0,0, 0,0,4'b0100,0,0,0);
        vecs[17] = mkVec(1,0,0,4'b1110,4'b1111,2'b11,1,1,1,1,0, 0,0,4'b0100,0,0,0);

        reset_n = 1'b0;
        en = 1'b0; flush = 1'b0; valid_e = 1'b0; cond_e = 4'b0000;
        alu_flags = 4'b0000; flag_write_e = 2'b00; reg_write_e = 1'b0;
        mem_write_e = 1'b0; pc_src_e = 1'b0; branch_e = 1'b0; no_write_e = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset flags", flags, 4'b0000);
        checkVal("reset M regs", {1'b0, reg_write_m, mem_write_m, pc_src_m}, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d", i));
        end

        // Load nonzero state, then pulse reset mid-cycle during a stalled flush.
        applyStimulus(mkVec(1,0,1,4'b1110,4'b1010,2'b11,1,1,1,0,0, 1,0,4'b1010,1,1,1), "preReset");
        checkOutput("preReset");
        en = 1'b0;
        flush = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        checkVal("midReset flags", flags, 4'b0000);
        checkVal("midReset M regs", {1'b0, reg_write_m, mem_write_m, pc_src_m}, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(mkVec(1,0,1,4'b1110,4'b1111,2'b11,0,0,0,0,0, 1,0,4'b1111,0,0,0), "postReset");
        checkOutput("postReset");

        // Exhaustive sweep: load each flag value, then test every code while stalled.
        for (int f = 0; f < 16; f++) begin
            applyStimulus(mkVec(1,0,1,4'b1110,4'(f),2'b11,0,0,0,0,0, 1,0,4'(f),0,0,0), $sformatf("load%0d", f));
            checkOutput($sformatf("load%0d", f));
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                en = 1'b0;
                flush = 1'b0;
                valid_e = 1'b1;
                cond_e = 4'(c);
                #1;
                checkVal($sformatf("sweep c=%0d f=%0d", c, f), {3'b0, cond_ex_e}, {3'b0, refCond(4'(c), 4'(f))});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
